// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter giving two requesters (0 = Icache, 1 = Dcache)
//   shared access to a single memory-controller command port. One
//   transaction is in flight at a time: grant, issue, wait for memory,
//   then a one-cycle turnaround before the next grant. All outputs are
//   registered.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid0/1              command valid from requester 0 / 1
//   req_rw0/1                 1 = write, 0 = read
//   req_addr0/1               command address
//   req_wdata0/1              write data
//   req_ready0/1              one-cycle completion pulse per requester
//   req_rdata                 shared read data, valid while a req_ready is high
//   mem_valid_data            command valid to memory
//   mem_rw_data               command direction to memory
//   mem_data_addr             address to memory
//   mem_data_wr               write data to memory
//   mem_data_rd               read data from memory
//   mem_ready_data            one-cycle completion pulse from memory
//   last_grant                ID of the most recently granted requester
//   error                     sticky wait-timeout flag
module mem_port_arbiter #(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 28,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid0,
    input  logic              req_valid1,
    input  logic              req_rw0,
    input  logic              req_rw1,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic              req_ready0,
    output logic              req_ready1,
    output logic [DATA_W-1:0] req_rdata,
    output logic              mem_valid_data,
    output logic              mem_rw_data,
    output logic [ADDR_W-1:0] mem_data_addr,
    output logic [DATA_W-1:0] mem_data_wr,
    input  logic [DATA_W-1:0] mem_data_rd,
    input  logic              mem_ready_data,
    output logic              last_grant,
    output logic              error
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state, state_nx;
    logic [7:0]          cnt, cnt_nx;
    logic                ready0_nx, ready1_nx;
    logic [DATA_W-1:0]   rdata_nx;
    logic                valid_nx;
    logic                rw_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic [DATA_W-1:0]   wr_nx;
    logic                last_nx;
    logic                err_nx;
    logic                grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            req_ready0     <= 1'b0;
            req_ready1     <= 1'b0;
            req_rdata      <= '0;
            mem_valid_data <= 1'b0;
            mem_rw_data    <= 1'b0;
            mem_data_addr  <= '0;
            mem_data_wr    <= '0;
            last_grant     <= 1'b1;
            error          <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            req_ready0     <= ready0_nx;
            req_ready1     <= ready1_nx;
            req_rdata      <= rdata_nx;
            mem_valid_data <= valid_nx;
            mem_rw_data    <= rw_nx;
            mem_data_addr  <= addr_nx;
            mem_data_wr    <= wr_nx;
            last_grant     <= last_nx;
            error          <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        ready0_nx = 1'b0;
        ready1_nx = 1'b0;
        rdata_nx  = req_rdata;
        valid_nx  = mem_valid_data;
        rw_nx     = mem_rw_data;
        addr_nx   = mem_data_addr;
        wr_nx     = mem_data_wr;
        last_nx   = last_grant;
        err_nx    = error;
        grant     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid0 || req_valid1) begin
                    // On a tie the requester that did not win last time goes first.
                    grant    = (req_valid0 && req_valid1) ? ~last_grant : req_valid1;
                    state_nx = ISSUE;
                    valid_nx = 1'b1;
                    last_nx  = grant;
                    rw_nx    = grant ? req_rw1    : req_rw0;
                    addr_nx  = grant ? req_addr1  : req_addr0;
                    wr_nx    = grant ? req_wdata1 : req_wdata0;
                end
            end
            ISSUE: begin
                state_nx = WAIT;
                cnt_nx   = '0;
            end
            WAIT: begin
                if (mem_ready_data) begin
                    valid_nx = 1'b0;
                    if (!mem_rw_data) rdata_nx = mem_data_rd;
                    // last_grant still identifies the owner of the transaction.
                    if (last_grant) ready1_nx = 1'b1;
                    else            ready0_nx = 1'b1;
                    state_nx = DONE;
                end else begin
                    if (cnt != 8'hFF) cnt_nx = cnt + 8'd1;
                    if (cnt_nx >= TIMEOUT_CNT) err_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a transaction-level model
//   predicts every output each cycle; directed scenarios pin single write,
//   round-robin order, read data, timeout and asynchronous reset.
module tb_mem_port_arbiter;

    localparam int DW = 256;
    localparam int AW = 28;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 0, v1 = 0, rw0 = 0, rw1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          ready0, ready1;
    logic [DW-1:0] rdata;
    logic          mvalid, mrw;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwr;
    logic [DW-1:0] mrd = '0;
    logic          mready = 1'b0;
    logic          lgrant, err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid0(v0), .req_valid1(v1),
        .req_rw0(rw0), .req_rw1(rw1),
        .req_addr0(addr0), .req_addr1(addr1),
        .req_wdata0(wd0), .req_wdata1(wd1),
        .req_ready0(ready0), .req_ready1(ready1),
        .req_rdata(rdata),
        .mem_valid_data(mvalid), .mem_rw_data(mrw),
        .mem_data_addr(maddr), .mem_data_wr(mwr),
        .mem_data_rd(mrd), .mem_ready_data(mready),
        .last_grant(lgrant), .error(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic          busy;      // a command is outstanding
        logic          issued;    // the first cycle after the grant has passed
        logic          turn;      // turnaround cycle after completion
        int unsigned   waited;    // unanswered cycles while waiting
        logic          id;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          last;
        logic          err;
        logic          rdy0;
        logic          rdy1;
    } model_t;

    function automatic model_t model_reset();
        model_t m;
        m.busy = 0; m.issued = 0; m.turn = 0; m.waited = 0;
        m.id = 0; m.rw = 0; m.addr = '0; m.wdata = '0; m.rdata = '0;
        m.last = 1; m.err = 0; m.rdy0 = 0; m.rdy1 = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t s, logic a0, logic a1,
                                          logic w0, logic w1,
                                          logic [AW-1:0] ad0, logic [AW-1:0] ad1,
                                          logic [DW-1:0] d0, logic [DW-1:0] d1,
                                          logic mr, logic [DW-1:0] md);
        model_t n = s;
        logic   who;
        n.rdy0 = 0;
        n.rdy1 = 0;
        if (s.turn) begin
            n.turn = 0;
        end else if (!s.busy) begin
            if (a0 || a1) begin
                who      = (a0 && a1) ? !s.last : a1;
                n.busy   = 1;
                n.issued = 0;
                n.waited = 0;
                n.id     = who;
                n.last   = who;
                n.rw     = who ? w1 : w0;
                n.addr   = who ? ad1 : ad0;
                n.wdata  = who ? d1 : d0;
            end
        end else if (!s.issued) begin
            n.issued = 1;
        end else if (mr) begin
            n.busy = 0;
            n.turn = 1;
            if (s.id) n.rdy1 = 1; else n.rdy0 = 1;
            if (!s.rw) n.rdata = md;
        end else begin
            n.waited = s.waited + 1;
            if (n.waited >= TO) n.err = 1;
        end
        return n;
    endfunction

    model_t m;
    initial m = model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, v0, v1, rw0, rw1, addr0, addr1, wd0, wd1, mready, mrd);
    end

    // ---------------- check helpers ----------------
    task automatic check1(input string name, input logic act, input logic exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic checki(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        check1("mem_valid", mvalid, m.busy);
        check1("mem_rw", mrw, m.rw);
        checkw("mem_addr", DW'(maddr), DW'(m.addr));
        checkw("mem_wr", mwr, m.wdata);
        check1("ready0", ready0, m.rdy0);
        check1("ready1", ready1, m.rdy1);
        checkw("rdata", rdata, m.rdata);
        check1("last_grant", lgrant, m.last);
        check1("error", err, m.err);
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d = '0;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic clear_inputs();
        v0 = 0; v1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
        mready = 0; mrd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1;
        clear_inputs();
        @(negedge clk); #1;
        rst = 0;
    endtask

    initial begin
        int vc, r0, r1, n, first_lg, seen, ok, nerr0, dropped;
        int ord [4];
        logic [127:0]  half;
        logic [DW-1:0] pat;

        // ---- single write from requester 0 ----
        do_reset();
        check1("reset_mem_valid", mvalid, 1'b0);
        check1("reset_last_grant", lgrant, 1'b1);
        check1("reset_error", err, 1'b0);
        checkw("reset_rdata", rdata, '0);
        checkw("reset_addr", DW'(maddr), '0);
        v0 = 1; rw0 = 1; addr0 = 28'h0001010; wd0 = rand_data();
        vc = 0; r0 = 0; r1 = 0; ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mvalid) begin
                vc++;
                if (mrw !== 1'b1 || maddr !== 28'h0001010) ok = 0;
            end
            if (ready0) r0++;
            if (ready1) r1++;
            #1;
            v0 = 0;
            mready = mvalid && (vc == 4);
        end
        checki("wr_valid_cycles", vc, 4);
        checki("wr_cmd_stable", ok, 1);
        checki("wr_ready0_pulses", r0, 1);
        checki("wr_ready1_pulses", r1, 0);
        check1("wr_last_grant", lgrant, 1'b0);
        check1("model_last_after_write", m.last, 1'b0);

        // ---- simultaneous and continuous requests: round robin ----
        do_reset();
        v0 = 1; rw0 = 0; addr0 = 28'h0000100;
        v1 = 1; rw1 = 1; addr1 = 28'h0000200; wd1 = rand_data();
        vc = 0; n = 0; seen = 0; first_lg = -1;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (mvalid && !seen) begin first_lg = int'(lgrant); seen = 1; end
            if (ready0 && n < 4) begin ord[n] = 0; n++; end
            if (ready1 && n < 4) begin ord[n] = 1; n++; end
            vc = mvalid ? vc + 1 : 0;
            #1;
            mready = mvalid && (vc == 2);
        end
        #1;
        v0 = 0; v1 = 0; mready = 0;
        checki("rr_first_last_grant", first_lg, 0);
        checki("rr_count", n, 4);
        checki("rr_order0", ord[0], 0);
        checki("rr_order1", ord[1], 1);
        checki("rr_order2", ord[2], 0);
        checki("rr_order3", ord[3], 1);

        // ---- read data path for requester 1 ----
        do_reset();
        half = 128'h11112222333344445555666677778888;
        pat = {half, half};
        v1 = 1; rw1 = 0; addr1 = 28'h0ABCDEF; mrd = pat;
        vc = 0; r1 = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready1) begin
                r1++;
                if (rdata === pat) ok = 1;
            end
            vc = mvalid ? vc + 1 : 0;
            #1;
            v1 = 0;
            mready = mvalid && (vc == 3);
        end
        checki("rd_ready1_pulses", r1, 1);
        checki("rd_data_during_ready", ok, 1);
        checkw("rd_data_held", rdata, pat);

        // ---- timeout: memory silent, then completes ----
        do_reset();
        v1 = 1; rw1 = 1; addr1 = 28'h0000040; wd1 = rand_data();
        nerr0 = 0; r1 = 0; seen = 0; dropped = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mvalid && !err) nerr0++;
            if (err) seen = 1;
            if (seen && !err) dropped++;
            if (ready1) r1++;
            #1;
            v1 = 0;
            mready = (i == 45);
        end
        checki("to_cycles_before_error", nerr0, TO + 1);
        checki("to_error_sticky", dropped, 0);
        checki("to_ready1_after_timeout", r1, 1);
        check1("to_error_final", err, 1'b1);

        // ---- reset while waiting ----
        do_reset();
        v0 = 1; rw0 = 1; addr0 = 28'h0012345; wd0 = rand_data();
        @(negedge clk); #1;
        v0 = 0;
        repeat (3) @(negedge clk);
        check1("rst_pre_valid", mvalid, 1'b1);
        #1;
        rst = 1;
        mready = 1;
        #1;
        check1("rst_async_valid", mvalid, 1'b0);
        check1("rst_async_rw", mrw, 1'b0);
        checkw("rst_async_addr", DW'(maddr), '0);
        checkw("rst_async_wr", mwr, '0);
        check1("rst_async_last", lgrant, 1'b1);
        r0 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ready0 || ready1) r0++;
        end
        #1;
        rst = 0;
        mready = 0;
        @(negedge clk);
        if (ready0 || ready1) r0++;
        checki("rst_no_ready_pulse", r0, 0);

        // ---- randomized traffic ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            v0    = ($urandom % 3) != 0;
            v1    = ($urandom % 3) != 0;
            rw0   = $urandom % 2;
            rw1   = $urandom % 2;
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            wd0   = rand_data();
            wd1   = rand_data();
            mrd   = rand_data();
            if (c < 1500)      mready = ($urandom % 3) == 0;
            else if (c < 2500) mready = ($urandom % 40) == 0;
            else               mready = ($urandom % 2) == 0;
            if (c == 2700) rst = 1;
            if (c == 2702) rst = 0;
        end
        @(negedge clk); #1;
        clear_inputs();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
